btn_pulse_conditioner: RTL and testbench

//  Conditions one raw push-button (B0, B1 or mode button) into clean single-cycle events for the

---
 rtl/btn_pulse_conditioner.sv | 177 +++++++++++++++++
 tb/tb_btn_pulse_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_conditioner.sv
// btn_pulse_conditioner
//   Turns one raw push-button into clean single-cycle events for the
//   clock/stopwatch/alarm controller: 2-FF synchronizer, debounce, then an
//   edge/hold event generator with auto-repeat for fast set-mode stepping.
//
// Ports
//   clk_100MHz     in   system clock, all logic on posedge
//   reset          in   synchronous active-low reset (0 = reset)
//   btn_in         in   raw asynchronous button, 1 = pressed
//   btn_level      out  debounced button level
//   press_pulse    out  one cycle on debounced 0->1
//   release_pulse  out  one cycle on debounced 1->0
//   long_pulse     out  one cycle when held LONG_PRESS_CYCLES after press
//   repeat_pulse   out  one cycle at the long point, then every REPEAT_CYCLES
//
// state   | meaning
// --------+---------------------------------------------------
// IDLE    | debounced level 0
// PRESSED | debounced level 1, counting toward the long point
// HELD    | debounced level 1, past long point, auto-repeating

module btn_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int REPEAT_CYCLES     = 20_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;

    logic              accept;
    logic              rise;
    logic              fall;

    always_comb begin
        s1_d       = btn_in;
        s2_d       = s1_q;

        // Debounce: the counter only runs while the synchronized input
        // disagrees with the accepted level; any agreement restarts it.
        level_d    = level_q;
        db_cnt_d   = '0;
        accept     = 1'b0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                accept  = 1'b1;
                level_d = s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        rise = accept & s2_q;
        fall = accept & ~s2_q;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            PRESSED: begin
                // A release landing on the long point wins over long/repeat.
                if (fall) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = HELD;
                    long_d     = 1'b1;
                    repeat_d   = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            HELD: begin
                if (fall) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end
        endcase
    end

    // Reset drops straight to IDLE without a release event; a button still
    // held afterwards has to re-debounce as a fresh press.
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_btn_pulse_conditioner.sv
// tb_btn_pulse_conditioner
//   Drives btn_pulse_conditioner with directed scenarios and random button
//   activity; a timestamp-based model predicts every output each cycle.
//   Small parameters keep the run short.

module tb_btn_pulse_conditioner;

    localparam int D = 4;
    localparam int L = 20;
    localparam int R = 5;

    logic clk = 1'b0;
    logic reset;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;

    always #5 clk = ~clk;

    btn_pulse_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES    (R)
    ) dut (
        .clk_100MHz   (clk),
        .reset        (reset),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model: two-sample input delay, run length of disagreement, press timestamp
    logic m_p0, m_p1, m_level, m_held;
    int   m_run, m_ptime;
    logic e_press, e_release, e_long, e_repeat;

    // observed events since the last clear_obs
    int n_press, n_release, n_long, n_repeat;
    int c_press, c_release, c_long;
    int rep_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic s2;
        int   dt;
        if (!r) begin
            m_p0 = 0; m_p1 = 0; m_level = 0; m_run = 0; m_held = 0;
            e_press = 0; e_release = 0; e_long = 0; e_repeat = 0;
        end else begin
            s2   = m_p1;
            m_p1 = m_p0;
            m_p0 = b;
            e_press   = 0;
            e_release = 0;
            if (s2 != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = s2;
                    m_run   = 0;
                    if (s2) e_press = 1; else e_release = 1;
                end
            end else begin
                m_run = 0;
            end
            if (e_press) begin
                m_held  = 1;
                m_ptime = cyc;
            end
            if (e_release) m_held = 0;
            dt       = cyc - m_ptime;
            e_long   = m_held && !e_press && (dt == L);
            e_repeat = m_held && !e_press && (dt >= L) && (((dt - L) % R) == 0);
        end
    endtask

    task automatic clear_obs();
        n_press = 0; n_release = 0; n_long = 0; n_repeat = 0;
        c_press = -1000; c_release = -1000; c_long = -1000;
        rep_q.delete();
    endtask

    task automatic step(input logic b, input logic r);
        btn_in = b;
        reset  = r;
        @(posedge clk);
        cyc++;
        model_edge(b, r);
        @(negedge clk);
        check("cycle_outputs",
              int'({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}),
              int'({m_level, e_press, e_release, e_long, e_repeat}));
        if (press_pulse)   begin n_press++;   c_press   = cyc; end
        if (release_pulse) begin n_release++; c_release = cyc; end
        if (long_pulse)    begin n_long++;    c_long    = cyc; end
        if (repeat_pulse)  begin n_repeat++;  rep_q.push_back(cyc); end
    endtask

    task automatic wait_press(output int p);
        for (int i = 0; i < 20 && n_press == 0; i++) step(1'b1, 1'b1);
        check("press_seen", n_press, 1);
        p = c_press;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, p, rst_edge, r0, r3;
        btn_in = 1'b0;
        reset  = 1'b0;
        clear_obs();

        repeat (3) step(1'b0, 1'b0);
        check("reset_outputs",
              int'({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);

        // 1: short press, no long
        repeat (12) step(1'b0, 1'b1);
        clear_obs();
        n = cyc + 1;
        repeat (10) step(1'b1, 1'b1);
        m = cyc + 1;
        repeat (12) step(1'b0, 1'b1);
        check("t1_press_count", n_press, 1);
        check("t1_press_latency", c_press - n, 5);
        check("t1_release_count", n_release, 1);
        check("t1_release_latency", c_release - m, 5);
        check("t1_long_count", n_long, 0);

        // 2: bounce 1,1,1,0 then stable 1
        clear_obs();
        n = cyc + 1;
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b1);
        check("t2_press_count", n_press, 1);
        check("t2_press_latency", c_press - n, 9);
        repeat (12) step(1'b0, 1'b1);
        check("t2_release_count", n_release, 1);

        // 3: long hold with repeats
        clear_obs();
        wait_press(p);
        while (cyc < p + 32) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        r0 = (rep_q.size() > 0) ? rep_q[0] - p : -1;
        r3 = (rep_q.size() > 3) ? rep_q[3] - p : -1;
        check("t3_long_count", n_long, 1);
        check("t3_long_offset", c_long - p, 20);
        check("t3_repeat_count", n_repeat, 4);
        check("t3_repeat_first", r0, 20);
        check("t3_repeat_last", r3, 35);
        check("t3_release_offset", c_release - p, 38);

        // 4: two-cycle glitch while held
        clear_obs();
        wait_press(p);
        while (cyc < p + 32)
            step(((cyc + 1 == p + 5) || (cyc + 1 == p + 6)) ? 1'b0 : 1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        check("t4_long_offset", c_long - p, 20);
        check("t4_release_count", n_release, 1);
        check("t4_release_offset", c_release - p, 38);

        // 5: reset while HELD with button still down
        clear_obs();
        wait_press(p);
        while (cyc < p + 22) step(1'b1, 1'b1);
        rst_edge = cyc + 1;
        step(1'b1, 1'b0);
        check("t5_outputs_cleared",
              int'({btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
        repeat (15) step(1'b1, 1'b1);
        check("t5_no_release", n_release, 0);
        check("t5_press_count", n_press, 2);
        check("t5_repress_offset", c_press - rst_edge, 6);
        repeat (12) step(1'b0, 1'b1);
        check("t5_release_count", n_release, 1);

        // 6: release accepted exactly on the long point
        clear_obs();
        wait_press(p);
        while (cyc < p + 14) step(1'b1, 1'b1);
        repeat (12) step(1'b0, 1'b1);
        check("t6_release_offset", c_release - p, 20);
        check("t6_long_count", n_long, 0);
        check("t6_repeat_count", n_repeat, 0);

        // random button activity with occasional reset
        for (int k = 0; k < 200; k++) begin
            logic b;
            int   len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 35);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 150) == 0) step(b, 1'b0);
                else                             step(b, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
